// File: rtl/systolic_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : systolic_job_arbiter
// Purpose  : Round-robin sharing of one systolic array among R requesters;
//            whole-matrix jobs in, id-tagged result matrices out.
// Option   : SA_ARB_TIMEOUT_EN adds o_rspError and a result watchdog.
// Revision : 1.0  initial release
// ============================================================================
module systolic_job_arbiter #(
    parameter  int N    = 4,
    parameter  int R    = 2,
    localparam int ID_W = $clog2(R)
) (
    input  logic                             i_clk,
    input  logic                             i_arst,
    input  logic [R-1:0]                     i_reqValid,
    output logic [R-1:0]                     o_reqReady,
    input  logic [R-1:0][N-1:0][N-1:0][7:0]  i_reqA,
    input  logic [R-1:0][N-1:0][N-1:0][7:0]  i_reqB,
    output logic [N-1:0][N-1:0][7:0]         o_saA,
    output logic [N-1:0][N-1:0][7:0]         o_saB,
    output logic                             o_saValidInput,
    input  logic [N-1:0][N-1:0][31:0]        i_saC,
    input  logic                             i_saValidResult,
    output logic                             o_rspValid,
    output logic [ID_W-1:0]                  o_rspId,
    output logic [N-1:0][N-1:0][31:0]        o_rspC,
    input  logic                             i_rspReady,
`ifdef SA_ARB_TIMEOUT_EN
    output logic                             o_rspError,
`endif
    output logic                             o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]                 rst_sync_q, rst_sync_d;
    logic                       w_rst;
    logic [1:0]                 state_q, state_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic [N-1:0][N-1:0][7:0]   a_q, a_d;
    logic [N-1:0][N-1:0][7:0]   b_q, b_d;
    logic [N-1:0][N-1:0][31:0]  c_q, c_d;
    logic [ID_W-1:0]            grant_idx;
    logic                       grant_any;
    int unsigned                scan_idx;

`ifdef SA_ARB_TIMEOUT_EN
    localparam int TMO  = 4 * N;
    localparam int WD_W = $clog2(TMO);
    logic [WD_W-1:0]            wdog_q, wdog_d;
    logic                       err_q, err_d;
`endif

    // Reset asserts immediately but releases on a clock edge.
    assign rst_sync_d = {rst_sync_q[0], 1'b0};
    assign w_rst      = rst_sync_q[1];

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Scan from highest offset down so the nearest set bit after ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int i = R - 1; i >= 0; i--) begin
            scan_idx = (int'(ptr_q) + i) % R;
            if (i_reqValid[ID_W'(scan_idx)]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        o_reqReady = '0;
`ifdef SA_ARB_TIMEOUT_EN
        wdog_d     = wdog_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_any && !w_rst) begin
                    o_reqReady[grant_idx] = 1'b1;
                    id_d    = grant_idx;
                    a_d     = i_reqA[grant_idx];
                    b_d     = i_reqB[grant_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SA_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_saValidResult) begin
                    c_d     = i_saC;
                    state_d = S_RESP;
                end
`ifdef SA_ARB_TIMEOUT_EN
                else if (wdog_q == WD_W'(TMO - 1)) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (i_rspReady) begin
                    ptr_d   = (id_q == ID_W'(R - 1)) ? '0 : id_q + 1'b1;
                    state_d = S_IDLE;
`ifdef SA_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
`ifdef SA_ARB_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
`ifdef SA_ARB_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign o_saA          = a_q;
    assign o_saB          = b_q;
    assign o_saValidInput = (state_q == S_ISSUE);
    assign o_rspValid     = (state_q == S_RESP);
    assign o_rspId        = id_q;
    assign o_rspC         = c_q;
    assign o_busy         = (state_q != S_IDLE);
`ifdef SA_ARB_TIMEOUT_EN
    assign o_rspError     = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_job_arbiter
// Purpose  : Directed bench for systolic_job_arbiter with a job-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_job_arbiter;

    localparam int N       = 4;
    localparam int R       = 2;
    localparam int ID_W    = $clog2(R);
    localparam int ARR_LAT = 3;
    localparam int AW      = N * N * 8;
    localparam int CW      = N * N * 32;

    typedef logic [N-1:0][N-1:0][7:0]  mat8_t;
    typedef logic [N-1:0][N-1:0][31:0] mat32_t;

    logic                             i_clk = 1'b0;
    logic                             i_arst;
    logic [R-1:0]                     i_reqValid;
    logic [R-1:0]                     o_reqReady;
    logic [R-1:0][N-1:0][N-1:0][7:0]  i_reqA;
    logic [R-1:0][N-1:0][N-1:0][7:0]  i_reqB;
    mat8_t                            o_saA;
    mat8_t                            o_saB;
    logic                             o_saValidInput;
    mat32_t                           i_saC;
    logic                             i_saValidResult;
    logic                             o_rspValid;
    logic [ID_W-1:0]                  o_rspId;
    mat32_t                           o_rspC;
    logic                             i_rspReady;
    logic                             o_busy;
`ifdef SA_ARB_TIMEOUT_EN
    logic                             o_rspError;
`endif

    systolic_job_arbiter #(.N(N), .R(R)) dut (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_reqValid      (i_reqValid),
        .o_reqReady      (o_reqReady),
        .i_reqA          (i_reqA),
        .i_reqB          (i_reqB),
        .o_saA           (o_saA),
        .o_saB           (o_saB),
        .o_saValidInput  (o_saValidInput),
        .i_saC           (i_saC),
        .i_saValidResult (i_saValidResult),
        .o_rspValid      (o_rspValid),
        .o_rspId         (o_rspId),
        .o_rspC          (o_rspC),
        .i_rspReady      (i_rspReady),
`ifdef SA_ARB_TIMEOUT_EN
        .o_rspError      (o_rspError),
`endif
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Stimulus control
    int jobs_req[R] = '{default: 0};
    int jobs_acc[R] = '{default: 0};
    bit ident_mode  = 1'b0;
    bit arr_en      = 1'b1;
    int stray_cnt   = 0;
    int stray_done  = 0;

    // Model state: one job in flight, tracked as a transaction
    int     m_ptr = 0;
    bit     m_busy = 0, m_issue = 0, m_wait = 0, m_rsp = 0, m_err = 0;
    int     m_id = 0, m_wcnt = 0;
    mat8_t  m_A, m_B;
    mat32_t m_C;
    int     n_done = 0, n_pulse = 0;
    mat32_t last_C;
    int     ids_q[$];

    task automatic check_i(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_m8(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_m32(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mat8_t fill8(input logic [7:0] v);
        mat8_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = v;
        return m;
    endfunction

    function automatic mat32_t fill32(input logic [31:0] v);
        mat32_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = v;
        return m;
    endfunction

    function automatic mat8_t ident8();
        mat8_t m = '0;
        for (int i = 0; i < N; i++) m[i][i] = 8'd1;
        return m;
    endfunction

    function automatic mat8_t ramp8(input logic [7:0] base);
        mat8_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = base + 8'(i * N + j);
        return m;
    endfunction

    function automatic mat32_t matmul(input mat8_t a, input mat8_t b);
        mat32_t c;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < N; k++) c[i][j] += 32'(a[i][k]) * 32'(b[k][j]);
            end
        return c;
    endfunction

    // Round-robin rule: first valid requester at or after the pointer, wrapping.
    function automatic int rr_pick(input int ptr, input logic [R-1:0] v);
        for (int off = 0; off < R; off++)
            if (v[(ptr + off) % R]) return (ptr + off) % R;
        return -1;
    endfunction

    // Requester driver: each requester keeps valid high while it has jobs left.
    initial begin
        i_reqValid = '0;
        i_reqA     = '0;
        i_reqB     = '0;
        forever begin
            @(negedge i_clk);
            for (int r = 0; r < R; r++)
                if (o_reqReady[r] && i_reqValid[r] && !i_arst) jobs_acc[r]++;
            @(posedge i_clk);
            #1;
            for (int r = 0; r < R; r++) begin
                i_reqValid[r] = (jobs_acc[r] < jobs_req[r]) && !i_arst;
                if (ident_mode) begin
                    i_reqA[r] = ident8();
                    i_reqB[r] = fill8(8'd2);
                end else begin
                    i_reqA[r] = fill8(8'(16 * r + jobs_acc[r] + 1));
                    i_reqB[r] = ramp8(8'(r + jobs_acc[r]));
                end
            end
        end
    end

    // Array stand-in: fixed latency, C = A*B; also emits stray result pulses on demand.
    initial begin
        mat32_t c;
        i_saValidResult = 1'b0;
        i_saC           = '0;
        forever begin
            @(negedge i_clk);
            if (o_saValidInput && arr_en) begin
                c = matmul(o_saA, o_saB);
                repeat (ARR_LAT) @(posedge i_clk);
                #1;
                if (!i_arst) begin
                    i_saValidResult = 1'b1;
                    i_saC           = c;
                end
                @(posedge i_clk);
                #1;
                i_saValidResult = 1'b0;
            end else if (stray_done != stray_cnt) begin
                stray_done++;
                @(posedge i_clk);
                #1;
                i_saValidResult = 1'b1;
                i_saC           = fill32(32'hdead);
                @(posedge i_clk);
                #1;
                i_saValidResult = 1'b0;
            end
        end
    end

    // Compare process: checks every cycle out of reset, then advances the model.
    initial begin
        logic [R-1:0] exp_ready;
        int g;
        forever begin
            @(negedge i_clk);
            if (i_arst) begin
                m_ptr = 0; m_busy = 0; m_issue = 0; m_wait = 0; m_rsp = 0; m_err = 0;
            end else begin
                g = m_busy ? -1 : rr_pick(m_ptr, i_reqValid);
                exp_ready = '0;
                if (g >= 0) exp_ready[g] = 1'b1;
                check_i("reqReady", 32'(o_reqReady), 32'(exp_ready));
                check_i("saValidInput", 32'(o_saValidInput), 32'(m_issue));
                check_i("busy", 32'(o_busy), 32'(m_busy));
                check_i("rspValid", 32'(o_rspValid), 32'(m_rsp));
                if (m_issue || m_wait) begin
                    check_m8("saA", o_saA, m_A);
                    check_m8("saB", o_saB, m_B);
                end
                if (m_rsp) begin
                    check_i("rspId", 32'(o_rspId), 32'(m_id));
                    check_m32("rspC", o_rspC, m_C);
                end
`ifdef SA_ARB_TIMEOUT_EN
                check_i("rspError", 32'(o_rspError), 32'(m_rsp && m_err));
`endif
                if (o_saValidInput) n_pulse++;

                if (m_rsp) begin
                    if (i_rspReady) begin
                        last_C = o_rspC;
                        ids_q.push_back(int'(o_rspId));
                        n_done++;
                        m_rsp  = 0;
                        m_busy = 0;
                        m_err  = 0;
                        m_ptr  = (m_id + 1) % R;
                    end
                end else if (m_wait) begin
                    m_wcnt++;
                    if (i_saValidResult) begin
                        m_wait = 0; m_rsp = 1; m_C = i_saC;
                    end
`ifdef SA_ARB_TIMEOUT_EN
                    else if (m_wcnt == 4 * N) begin
                        m_wait = 0; m_rsp = 1; m_C = '0; m_err = 1;
                    end
`endif
                end else if (m_issue) begin
                    m_issue = 0; m_wait = 1; m_wcnt = 0;
                end else if (g >= 0) begin
                    m_busy = 1; m_issue = 1; m_id = g;
                    m_A = i_reqA[g]; m_B = i_reqB[g];
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_i({tag, "_reqReady"}, 32'(o_reqReady), 32'd0);
        check_i({tag, "_saValid"}, 32'(o_saValidInput), 32'd0);
        check_i({tag, "_rspValid"}, 32'(o_rspValid), 32'd0);
        check_i({tag, "_rspId"}, 32'(o_rspId), 32'd0);
        check_i({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_m32({tag, "_rspC"}, o_rspC, '0);
        check_m8({tag, "_saA"}, o_saA, '0);
        check_m8({tag, "_saB"}, o_saB, '0);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1 i_arst = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("reset");
        @(posedge i_clk);
        #1 i_arst = 1'b0;
        repeat (4) @(posedge i_clk);
    endtask

    task automatic wait_jobs(input string name, input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(posedge i_clk);
            k++;
        end
        check_i({name, "_jobs_done"}, 32'(n_done), 32'(target));
    endtask

    task automatic wait_out(input string name, input bit want_rsp, input int budget, output int cycles);
        bit seen = 0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge i_clk);
            cycles++;
            seen = want_rsp ? o_rspValid : o_saValidInput;
        end
        check_i({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int base, cyc, rdy_seen;
        mat32_t c0;
        i_arst     = 1'b1;
        i_rspReady = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("por");
        @(posedge i_clk);
        #1 i_arst = 1'b0;
        repeat (4) @(posedge i_clk);

        // Single request: A = I, B = all 2s -> C = all 2s, id 0, one issue pulse
        ident_mode  = 1'b1;
        jobs_req[0] = 1;
        wait_jobs("single", 1, 60);
        check_i("single_id", 32'(ids_q[0]), 32'd0);
        check_m32("single_C", last_C, fill32(32'd2));
        check_i("single_pulses", 32'(n_pulse), 32'd1);
        ident_mode  = 1'b0;

        // Contention from reset: R0 then R1
        do_reset();
        ids_q.delete();
        base = n_done;
        jobs_req[0]++;
        jobs_req[1]++;
        wait_jobs("contention", base + 2, 80);
        if (ids_q.size() >= 2) begin
            check_i("cont_first", 32'(ids_q[0]), 32'd0);
            check_i("cont_second", 32'(ids_q[1]), 32'd1);
        end

        // Fairness: R0 always requesting, R1 joins after the first job
        ids_q.delete();
        base = n_done;
        jobs_req[0] += 2;
        wait_jobs("fair_a", base + 1, 60);
        jobs_req[1] += 2;
        wait_jobs("fair_b", base + 4, 150);
        if (ids_q.size() >= 4) begin
            check_i("fair_0", 32'(ids_q[0]), 32'd0);
            check_i("fair_1", 32'(ids_q[1]), 32'd1);
            check_i("fair_2", 32'(ids_q[2]), 32'd0);
            check_i("fair_3", 32'(ids_q[3]), 32'd1);
        end

        // Backpressure: response held for 10 cycles, no new grant meanwhile
        base = n_done;
        @(posedge i_clk);
        #1 i_rspReady = 1'b0;
        jobs_req[0]++;
        jobs_req[1]++;
        wait_out("bp_rsp", 1'b1, 60, cyc);
        c0 = o_rspC;
        rdy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_reqReady != '0) rdy_seen++;
            check_m32("bp_stable_C", o_rspC, c0);
        end
        check_i("bp_no_ready", 32'(rdy_seen), 32'd0);
        @(posedge i_clk);
        #1 i_rspReady = 1'b1;
        wait_jobs("bp", base + 2, 80);

        // Reset while waiting on the array: job dropped, next job completes
        arr_en = 1'b0;
        base   = n_done;
        jobs_req[0]++;
        wait_out("rw_issue", 1'b0, 40, cyc);
        repeat (2) @(posedge i_clk);
        #1 i_arst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("rw");
        @(posedge i_clk);
        #1 i_arst = 1'b0;
        repeat (6) @(posedge i_clk);
        check_i("rw_no_rsp", 32'(n_done), 32'(base));
        arr_en = 1'b1;
        ids_q.delete();
        jobs_req[1]++;
        wait_jobs("rw_next", base + 1, 60);
        if (ids_q.size() >= 1) check_i("rw_next_id", 32'(ids_q[0]), 32'd1);

        // Stray array result while idle is ignored
        stray_cnt++;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        check_i("stray_idle", 32'(o_busy), 32'd0);

`ifdef SA_ARB_TIMEOUT_EN
        // Watchdog: no result -> error response 4*N+1 cycles after the issue pulse
        arr_en = 1'b0;
        base   = n_done;
        jobs_req[0]++;
        wait_out("to_issue", 1'b0, 40, cyc);
        wait_out("to_rsp", 1'b1, 100, cyc);
        check_i("to_latency", 32'(cyc), 32'(4 * N + 1));
        check_i("to_error", 32'(o_rspError), 32'd1);
        check_m32("to_C", o_rspC, '0);
        wait_jobs("to", base + 1, 10);
        arr_en = 1'b1;
`endif

        repeat (3) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
